multi_lane_fifo: RTL and testbench

Parametrised multi-push/multi-pop FIFO: up to N words enter and up to N words leave per clock, with an arbitrary (non-power-of-two) depth. It adds an occupancy count, an almost-full threshold, sticky overflow/underflow error flags and a synchronous flush. It sits between multi-word producers and consumers in the UART/DSP datapath, for example a byte-lane packer feeding the FFT sample loader.

---
 rtl/multi_lane_fifo.sv | 133 +++++++++++++
 tb/tb_multi_lane_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_fifo.sv
// multi_lane_fifo
//   Multi-push / multi-pop FIFO. Up to N words enter and up to N words leave
//   per clock. The depth D can be any integer, so the pointers wrap modulo D.
//   The read side is first-word fall-through: pop_data always shows the oldest
//   entries, driven combinationally from registered state.
//
// Ports
//   clk          clock; all state changes on posedge
//   rstn         synchronous active-low reset (same effect as flush)
//   flush        synchronous clear; overrides any same-cycle push/pop
//   push         number of words to write this cycle (0..N)
//   push_data    N lanes; lane 0 is written first (oldest)
//   pop          number of words to read this cycle (0..N)
//   pop_data     lane i = (i+1)-th oldest entry; 0 for lanes i >= can_pop
//   can_push     min(N, D - count)
//   can_pop      min(N, count)
//   count        current occupancy
//   empty        count == 0
//   almost_full  count >= AF_LEVEL
//   overflow     sticky: a push request was rejected
//   underflow    sticky: a pop request was rejected
module multi_lane_fifo #(
  parameter int W        = 8,
  parameter int D        = 8,
  parameter int N        = 4,
  parameter int AF_LEVEL = D - 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic [$clog2(N+1)-1:0]    push,
  input  logic [N-1:0][W-1:0]       push_data,
  input  logic [$clog2(N+1)-1:0]    pop,
  output logic [N-1:0][W-1:0]       pop_data,
  output logic [$clog2(N+1)-1:0]    can_push,
  output logic [$clog2(N+1)-1:0]    can_pop,
  output logic [$clog2(D+1)-1:0]    count,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int WN = $clog2(N + 1);
  localparam int WC = $clog2(D + 1);
  localparam int WP = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  r_mem [D];
  logic [WP-1:0] r_wp;
  logic [WP-1:0] r_rp;
  logic [WC-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic [WC-1:0] w_space;
  logic [WN-1:0] w_can_push;
  logic [WN-1:0] w_can_pop;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_write_en;
  logic [WP-1:0] w_wp_next;
  logic [WP-1:0] w_rp_next;
  logic [WP-1:0] w_waddr [N];
  logic [WP-1:0] w_raddr [N];
  logic [N-1:0]  w_lane_we;

  // (base + off) mod D. base < D and off <= N <= D, so one conditional
  // subtract is enough; one extra bit holds the carry before correction.
  function automatic logic [WP-1:0] f_wrap(input logic [WP-1:0] base,
                                           input logic [WN-1:0] off);
    logic [WP:0] sum;
    sum = {1'b0, base} + (WP+1)'(off);
    if (sum >= (WP+1)'(D)) sum = sum - (WP+1)'(D);
    return sum[WP-1:0];
  endfunction

  // Both directions are judged against the current count only, so a
  // same-cycle pop never makes room for a push (and vice versa).
  assign w_space    = WC'(D) - r_count;
  assign w_can_push = (w_space >= WC'(N)) ? WN'(N) : WN'(w_space);
  assign w_can_pop  = (r_count >= WC'(N)) ? WN'(N) : WN'(r_count);
  assign w_push_ok  = (push <= w_can_push);
  assign w_pop_ok   = (pop <= w_can_pop);
  assign w_write_en = w_push_ok && rstn && !flush;
  assign w_wp_next  = f_wrap(r_wp, push);
  assign w_rp_next  = f_wrap(r_rp, pop);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign w_waddr[gi]   = f_wrap(r_wp, WN'(gi));
      assign w_raddr[gi]   = f_wrap(r_rp, WN'(gi));
      assign w_lane_we[gi] = w_write_en && (WN'(gi) < push);
      // Lanes beyond the valid occupancy read as zero, not stale memory.
      assign pop_data[gi]  = (WN'(gi) < w_can_pop) ? r_mem[w_raddr[gi]] : '0;
    end
  endgenerate

  // Storage has no reset: contents are don't-care until written, and the
  // read mask above hides anything not covered by count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (w_lane_we[k]) r_mem[w_waddr[k]] <= push_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wp <= w_wp_next;
      else           r_overflow <= 1'b1;
      if (w_pop_ok)  r_rp <= w_rp_next;
      else           r_underflow <= 1'b1;
      r_count <= r_count
               + (w_push_ok ? WC'(push) : WC'(0))
               - (w_pop_ok  ? WC'(pop)  : WC'(0));
    end
  end

  assign can_push    = w_can_push;
  assign can_pop     = w_can_pop;
  assign count       = r_count;
  assign empty       = (r_count == '0);
  assign almost_full = (r_count >= WC'(AF_LEVEL));
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_multi_lane_fifo.sv
// tb_multi_lane_fifo
//   Self-checking bench for multi_lane_fifo (W=8, D=8, N=4, AF_LEVEL=6).
//   A queue-based reference tracks the FIFO contents and sticky flags; every
//   clocked step is compared against it. A table of directed vectors and a few
//   hand sequences add explicit expectations, then random traffic follows.
module tb_multi_lane_fifo;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int N  = 4;
  localparam int AF = 6;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic [2:0]  push;
  logic [31:0] push_data;
  logic [2:0]  pop;
  logic [31:0] pop_data;
  logic [2:0]  can_push;
  logic [2:0]  can_pop;
  logic [3:0]  count;
  logic        empty;
  logic        almost_full;
  logic        overflow;
  logic        underflow;

  multi_lane_fifo #(.W(W), .D(D), .N(N), .AF_LEVEL(AF)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .push        (push),
    .push_data   (push_data),
    .pop         (pop),
    .pop_data    (pop_data),
    .can_push    (can_push),
    .can_pop     (can_pop),
    .count       (count),
    .empty       (empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: FIFO contents as a queue of words, plus sticky flags.
  int m_q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  typedef struct {
    bit          rstn;
    bit          flush;
    int          push;
    int          pop;
    logic [31:0] data;
    int          e_count;
    logic [31:0] e_pd;
    bit          e_ovf;
    bit          e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit f, input int p, input int o,
                              input logic [31:0] d);
    int sz;
    if (!r || f) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      sz = m_q.size();
      if (p > imin(N, D - sz)) m_ovf = 1'b1;
      if (o > imin(N, sz))     m_unf = 1'b1;
      if (o <= imin(N, sz))     for (int k = 0; k < o; k++) void'(m_q.pop_front());
      if (p <= imin(N, D - sz)) for (int k = 0; k < p; k++) m_q.push_back(int'(d[8*k +: 8]));
    end
  endtask

  task automatic check_model(input string tag);
    int          sz;
    logic [31:0] e_pd;
    sz   = m_q.size();
    e_pd = '0;
    for (int i = 0; i < imin(N, sz); i++) e_pd[8*i +: 8] = 8'(m_q[i]);
    chk({tag, ".m.count"},    64'(count),       64'(sz));
    chk({tag, ".m.can_push"}, 64'(can_push),    64'(imin(N, D - sz)));
    chk({tag, ".m.can_pop"},  64'(can_pop),     64'(imin(N, sz)));
    chk({tag, ".m.empty"},    64'(empty),       64'(sz == 0));
    chk({tag, ".m.af"},       64'(almost_full), 64'(sz >= AF));
    chk({tag, ".m.ovf"},      64'(overflow),    64'(m_ovf));
    chk({tag, ".m.unf"},      64'(underflow),   64'(m_unf));
    chk({tag, ".m.pd"},       64'(pop_data),    64'(e_pd));
  endtask

  task automatic step(input string tag, input bit r, input bit f, input int p,
                      input int o, input logic [31:0] d);
    rstn      = r;
    flush     = f;
    push      = 3'(p);
    pop       = 3'(o);
    push_data = d;
    @(posedge clk);
    #1;
    model_update(r, f, p, o, d);
    check_model(tag);
    $display("[TB] %s rstn=%0d flush=%0d push=%0d pop=%0d -> count=%0d pd=%08h ovf=%0d unf=%0d",
             tag, r, f, p, o, count, pop_data, overflow, underflow);
  endtask

  function automatic void add(bit r, bit f, int p, int o, logic [31:0] d,
                              int ec, logic [31:0] epd, bit eo, bit eu);
    vec_t v;
    v.rstn = r; v.flush = f; v.push = p; v.pop = o; v.data = d;
    v.e_count = ec; v.e_pd = epd; v.e_ovf = eo; v.e_unf = eu;
    vecs.push_back(v);
  endfunction

  initial begin
    rstn = 1'b0; flush = 1'b0; push = '0; pop = '0; push_data = '0;

    // Reset held three cycles; requests during reset must be ignored.
    for (int i = 0; i < 3; i++) step($sformatf("rst%0d", i), 1'b0, 1'b0, 2, 1, 32'hA5A5A5A5);
    chk("rst.count",    64'(count),       64'd0);
    chk("rst.can_push", 64'(can_push),    64'd4);
    chk("rst.can_pop",  64'(can_pop),     64'd0);
    chk("rst.empty",    64'(empty),       64'd1);
    chk("rst.af",       64'(almost_full), 64'd0);
    chk("rst.ovf",      64'(overflow),    64'd0);
    chk("rst.unf",      64'(underflow),   64'd0);
    chk("rst.pd",       64'(pop_data),    64'd0);

    //  rstn flush push pop data          count  pop_data       ovf unf
    add(1, 0, 3, 0, 32'h00030201, 3, 32'h00030201, 0, 0);   // basic
    add(1, 0, 0, 1, 32'h0,        2, 32'h00000302, 0, 0);
    add(1, 0, 0, 1, 32'h0,        1, 32'h00000003, 0, 0);
    add(1, 0, 0, 1, 32'h0,        0, 32'h00000000, 0, 0);
    add(1, 0, 4, 0, 32'h0D0C0B0A, 4, 32'h0D0C0B0A, 0, 0);   // full and wrap
    add(1, 0, 4, 0, 32'h11100F0E, 8, 32'h0D0C0B0A, 0, 0);
    add(1, 0, 0, 2, 32'h0,        6, 32'h0F0E0D0C, 0, 0);
    add(1, 0, 2, 0, 32'h00001312, 8, 32'h0F0E0D0C, 0, 0);
    add(1, 0, 0, 4, 32'h0,        4, 32'h13121110, 0, 0);
    add(1, 0, 0, 4, 32'h0,        0, 32'h00000000, 0, 0);
    add(1, 0, 4, 0, 32'h17161514, 4, 32'h17161514, 0, 0);   // errors
    add(1, 0, 3, 0, 32'h001A1918, 7, 32'h17161514, 0, 0);
    add(1, 0, 2, 0, 32'h0000EEFF, 7, 32'h17161514, 1, 0);
    add(1, 0, 0, 0, 32'h0,        7, 32'h17161514, 1, 0);
    add(1, 0, 0, 4, 32'h0,        3, 32'h001A1918, 1, 0);
    add(1, 0, 0, 1, 32'h0,        2, 32'h00001A19, 1, 0);
    add(1, 0, 0, 3, 32'h0,        2, 32'h00001A19, 1, 1);
    add(1, 0, 0, 1, 32'h0,        1, 32'h0000001A, 1, 1);
    add(1, 1, 0, 0, 32'h0,        0, 32'h00000000, 0, 0);
    add(1, 0, 4, 0, 32'h17161514, 4, 32'h17161514, 0, 0);   // simultaneous
    add(1, 0, 3, 2, 32'h001A1918, 5, 32'h19181716, 0, 0);
    add(1, 0, 4, 0, 32'hDDCCBBAA, 5, 32'h19181716, 1, 0);   // flush mid-op
    add(1, 1, 2, 0, 32'h0000BEEF, 0, 32'h00000000, 0, 0);
    add(1, 0, 1, 0, 32'h00000055, 1, 32'h00000055, 0, 0);
    add(1, 0, 4, 0, 32'h04030201, 5, 32'h03020155, 0, 0);
    add(1, 0, 4, 0, 32'h08070605, 5, 32'h03020155, 1, 0);
    add(0, 0, 2, 0, 32'h0000BEEF, 0, 32'h00000000, 0, 0);   // reset mid-op
    add(1, 0, 2, 0, 32'h00007766, 2, 32'h00007766, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("v%0d", i), vecs[i].rstn, vecs[i].flush, vecs[i].push,
           vecs[i].pop, vecs[i].data);
      chk($sformatf("v%0d.count", i), 64'(count),     64'(vecs[i].e_count));
      chk($sformatf("v%0d.pd", i),    64'(pop_data),  64'(vecs[i].e_pd));
      chk($sformatf("v%0d.ovf", i),   64'(overflow),  64'(vecs[i].e_ovf));
      chk($sformatf("v%0d.unf", i),   64'(underflow), 64'(vecs[i].e_unf));
    end

    // Full FIFO: a same-cycle pop does not make room for a push.
    step("h0", 1'b1, 1'b1, 0, 0, 32'h0);
    step("h1", 1'b1, 1'b0, 4, 0, 32'h34333231);
    step("h2", 1'b1, 1'b0, 4, 0, 32'h44434241);
    chk("h2.can_push", 64'(can_push), 64'd0);
    chk("h2.af",       64'(almost_full), 64'd1);
    step("h3", 1'b1, 1'b0, 4, 4, 32'h58575655);
    chk("h3.count", 64'(count),    64'd4);
    chk("h3.pd",    64'(pop_data), 64'h44434241);
    chk("h3.ovf",   64'(overflow), 64'd1);

    // Empty FIFO: a same-cycle push does not satisfy a pop.
    step("h4", 1'b1, 1'b1, 0, 0, 32'h0);
    step("h5", 1'b1, 1'b0, 4, 1, 32'h64636261);
    chk("h5.count", 64'(count),     64'd4);
    chk("h5.pd",    64'(pop_data),  64'h64636261);
    chk("h5.unf",   64'(underflow), 64'd1);
    chk("h5.ovf",   64'(overflow),  64'd0);

    // Random traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit f;
      r = ($urandom_range(0, 79) != 0);
      f = ($urandom_range(0, 39) == 0);
      step($sformatf("r%0d", i), r, f, int'($urandom_range(0, N)),
           int'($urandom_range(0, N)), $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
